// File: rtl/axi_fsrc_seq_timing_ctrl.sv
// Sequencer timing controller.
// Runs a repeating period of (gpio_change_cnt + 1) clk cycles. Each period start loads a GPIO
// word and pulses period_strb. Per-trigger assert/deassert offsets inside the period shape the
// trig_out levels. A one-shot rx_start pulse fires a programmable delay after the run begins.
// Deasserting seq_en lets the current period drain out before the block returns to idle.
module axi_fsrc_seq_timing_ctrl #(
    parameter int unsigned CTRL_WIDTH    = 40,
    parameter int unsigned COUNTER_WIDTH = 4,
    parameter int unsigned NUM_TRIG      = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              seq_en,
    input  logic                              seq_start,
    input  logic                              ext_trig_en,
    input  logic                              ext_trig,
    input  logic [31:0]                       gpio_change_cnt,
    input  logic [CTRL_WIDTH-1:0]             gpio_w,
    input  logic [NUM_TRIG*COUNTER_WIDTH-1:0] first_trig_cnt,
    input  logic [NUM_TRIG*COUNTER_WIDTH-1:0] second_trig_cnt,
    input  logic [COUNTER_WIDTH-1:0]          rx_delay_cnt,
    output logic [CTRL_WIDTH-1:0]             gpio_out,
    output logic [NUM_TRIG-1:0]               trig_out,
    output logic                              period_strb,
    output logic                              rx_start,
    output logic                              busy,
    output logic                              done
);

    typedef enum logic [1:0] {StIdle, StArm, StRun, StDrain} state_e;

    state_e                   state_q;
    logic [31:0]              pcnt_q;
    logic [31:0]              period_len_q;
    logic                     seq_start_q;
    logic                     ext_trig_q;
    logic                     edge_ok_q;
    logic [COUNTER_WIDTH-1:0] rx_cnt_q;
    logic                     rx_fired_q;

    logic                     start_evt;
    logic                     trig_evt;
    logic                     run_entry;
    logic                     period_wrap;
    logic                     rx_hit;
    logic [COUNTER_WIDTH-1:0] rx_cnt_inc;
    logic [NUM_TRIG-1:0]      trig_d;

    // Edge events, run entry and counter helpers.
    // edge_ok_q stays low for the first cycle after reset so an input already high at release
    // is not taken as a fresh edge.
    always_comb begin
        start_evt   = edge_ok_q & seq_start & ~seq_start_q;
        trig_evt    = edge_ok_q & ext_trig & ~ext_trig_q;
        run_entry   = ((state_q == StIdle) && start_evt && seq_en && !ext_trig_en) ||
                      ((state_q == StArm) && seq_en && trig_evt);
        period_wrap = (pcnt_q == period_len_q);
        rx_hit      = !rx_fired_q && (rx_cnt_q == rx_delay_cnt);
        rx_cnt_inc  = (rx_cnt_q == {COUNTER_WIDTH{1'b1}}) ? rx_cnt_q
                                                          : rx_cnt_q + COUNTER_WIDTH'(1);
    end

    // Next trigger levels: clear beats set; offsets beyond the period length never match.
    always_comb begin
        trig_d = trig_out;
        for (int unsigned i = 0; i < NUM_TRIG; i++) begin
            if ((32'(second_trig_cnt[i*COUNTER_WIDTH +: COUNTER_WIDTH]) == pcnt_q) &&
                (32'(second_trig_cnt[i*COUNTER_WIDTH +: COUNTER_WIDTH]) <= period_len_q)) begin
                trig_d[i] = 1'b0;
            end else if ((32'(first_trig_cnt[i*COUNTER_WIDTH +: COUNTER_WIDTH]) == pcnt_q) &&
                         (32'(first_trig_cnt[i*COUNTER_WIDTH +: COUNTER_WIDTH]) <= period_len_q)) begin
                trig_d[i] = 1'b1;
            end
        end
    end

    // Busy follows the state register directly, so reset clears it asynchronously.
    assign busy = (state_q != StIdle);

    // Sequencer FSM with counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            pcnt_q       <= 32'd0;
            period_len_q <= 32'd0;
            seq_start_q  <= 1'b0;
            ext_trig_q   <= 1'b0;
            edge_ok_q    <= 1'b0;
            rx_cnt_q     <= '0;
            rx_fired_q   <= 1'b0;
            gpio_out     <= '0;
            trig_out     <= '0;
            period_strb  <= 1'b0;
            rx_start     <= 1'b0;
            done         <= 1'b0;
        end else begin
            seq_start_q <= seq_start;
            ext_trig_q  <= ext_trig;
            edge_ok_q   <= 1'b1;
            period_strb <= 1'b0;
            rx_start    <= 1'b0;
            done        <= 1'b0;

            if (run_entry) begin
                state_q      <= StRun;
                pcnt_q       <= 32'd0;
                period_len_q <= gpio_change_cnt;
                gpio_out     <= gpio_w;
                period_strb  <= 1'b1;
                trig_out     <= '0;
                rx_cnt_q     <= '0;
                rx_fired_q   <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start_evt && seq_en && ext_trig_en) begin
                            state_q <= StArm;
                        end
                    end
                    StArm: begin
                        // seq_en low wins over a simultaneous trigger edge (run_entry needs seq_en).
                        if (!seq_en) begin
                            state_q <= StIdle;
                        end
                    end
                    StRun: begin
                        trig_out <= trig_d;
                        rx_cnt_q <= rx_cnt_inc;
                        if (rx_hit) begin
                            rx_start   <= 1'b1;
                            rx_fired_q <= 1'b1;
                        end
                        if (period_wrap) begin
                            pcnt_q       <= 32'd0;
                            period_len_q <= gpio_change_cnt;
                            gpio_out     <= gpio_w;
                            period_strb  <= 1'b1;
                        end else begin
                            pcnt_q <= pcnt_q + 32'd1;
                        end
                        // A drop that lands on the wrap drains the period that has just begun.
                        if (!seq_en) begin
                            state_q <= StDrain;
                        end
                    end
                    StDrain: begin
                        if (period_wrap) begin
                            state_q  <= StIdle;
                            pcnt_q   <= 32'd0;
                            trig_out <= '0;
                            done     <= 1'b1;
                        end else begin
                            pcnt_q   <= pcnt_q + 32'd1;
                            trig_out <= trig_d;
                            rx_cnt_q <= rx_cnt_inc;
                            if (rx_hit) begin
                                rx_start   <= 1'b1;
                                rx_fired_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_fsrc_seq_timing_ctrl.sv
// Directed bench for axi_fsrc_seq_timing_ctrl: a vector table for the basic run plus
// hand-written sequences for drain, external trigger, boundaries and reset.
module tb_axi_fsrc_seq_timing_ctrl;

    localparam int unsigned CW = 40;
    localparam int unsigned NW = 4;
    localparam int unsigned NT = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           seq_en;
    logic           seq_start;
    logic           ext_trig_en;
    logic           ext_trig;
    logic [31:0]    gpio_change_cnt;
    logic [CW-1:0]  gpio_w;
    logic [NT*NW-1:0] first_trig_cnt;
    logic [NT*NW-1:0] second_trig_cnt;
    logic [NW-1:0]  rx_delay_cnt;
    logic [CW-1:0]  gpio_out;
    logic [NT-1:0]  trig_out;
    logic           period_strb;
    logic           rx_start;
    logic           busy;
    logic           done;

    int n_cmp = 0;
    int n_err = 0;

    axi_fsrc_seq_timing_ctrl #(
        .CTRL_WIDTH   (CW),
        .COUNTER_WIDTH(NW),
        .NUM_TRIG     (NT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .seq_en         (seq_en),
        .seq_start      (seq_start),
        .ext_trig_en    (ext_trig_en),
        .ext_trig       (ext_trig),
        .gpio_change_cnt(gpio_change_cnt),
        .gpio_w         (gpio_w),
        .first_trig_cnt (first_trig_cnt),
        .second_trig_cnt(second_trig_cnt),
        .rx_delay_cnt   (rx_delay_cnt),
        .gpio_out       (gpio_out),
        .trig_out       (trig_out),
        .period_strb    (period_strb),
        .rx_start       (rx_start),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       start;
        logic       busy;
        logic       strb;
        logic [3:0] trig;
        logic       rx;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mk(input logic en, input logic st, input logic bz, input logic sb,
                                input logic [3:0] tg, input logic rx);
        vec_t v;
        v.en    = en;
        v.start = st;
        v.busy  = bz;
        v.strb  = sb;
        v.trig  = tg;
        v.rx    = rx;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic start_run();
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int seen;
        seen = 0;
        for (int c = 0; c < budget && seen == 0; c++) begin
            tick();
            if (done === 1'b1) seen = 1;
        end
        check(name, 64'(seen), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".gpio"}, 64'(gpio_out), 64'd0);
        check({tag, ".trig"}, 64'(trig_out), 64'd0);
        check({tag, ".strb"}, 64'(period_strb), 64'd0);
        check({tag, ".rx"},   64'(rx_start), 64'd0);
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".done"}, 64'(done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // trig0: 2/5, trig1: 1/1 (clear wins), trig2: 15/0 (beyond period), trig3: 0/9
        tbl[0]  = mk(1, 1, 1, 1, 4'h0, 0);
        tbl[1]  = mk(1, 0, 1, 0, 4'h8, 0);
        tbl[2]  = mk(1, 0, 1, 0, 4'h8, 0);
        tbl[3]  = mk(1, 0, 1, 0, 4'h9, 0);
        tbl[4]  = mk(1, 0, 1, 0, 4'h9, 1);
        tbl[5]  = mk(1, 0, 1, 0, 4'h9, 0);
        tbl[6]  = mk(1, 0, 1, 0, 4'h8, 0);
        tbl[7]  = mk(1, 0, 1, 0, 4'h8, 0);
        tbl[8]  = mk(1, 0, 1, 0, 4'h8, 0);
        tbl[9]  = mk(1, 0, 1, 0, 4'h8, 0);
        tbl[10] = mk(1, 0, 1, 1, 4'h0, 0);
        tbl[11] = mk(1, 1, 1, 0, 4'h8, 0);  // start edge while running is ignored
        tbl[12] = mk(1, 0, 1, 0, 4'h8, 0);
        tbl[13] = mk(1, 0, 1, 0, 4'h9, 0);
        tbl[14] = mk(1, 0, 1, 0, 4'h9, 0);
        tbl[15] = mk(1, 0, 1, 0, 4'h9, 0);
        tbl[16] = mk(1, 0, 1, 0, 4'h8, 0);
        tbl[17] = mk(1, 0, 1, 0, 4'h8, 0);
        tbl[18] = mk(1, 0, 1, 0, 4'h8, 0);
        tbl[19] = mk(1, 0, 1, 0, 4'h8, 0);
        tbl[20] = mk(1, 0, 1, 1, 4'h0, 0);
        tbl[21] = mk(1, 0, 1, 0, 4'h8, 0);
        tbl[22] = mk(1, 0, 1, 0, 4'h8, 0);
        tbl[23] = mk(1, 0, 1, 0, 4'h9, 0);

        reset           = 1'b1;
        seq_en          = 1'b0;
        seq_start       = 1'b0;
        ext_trig_en     = 1'b0;
        ext_trig        = 1'b0;
        gpio_change_cnt = 32'd9;
        gpio_w          = 40'hA5;
        first_trig_cnt  = {4'd0, 4'd15, 4'd1, 4'd2};
        second_trig_cnt = {4'd9, 4'd0, 4'd1, 4'd5};
        rx_delay_cnt    = 4'd3;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset  = 1'b0;
        seq_en = 1'b1;
        tick();
        tick();

        // Basic run, one table row per cycle
        for (int r = 0; r < 24; r++) begin
            seq_en    = tbl[r].en;
            seq_start = tbl[r].start;
            tick();
            check($sformatf("basic[%0d].busy", r), 64'(busy), 64'(tbl[r].busy));
            check($sformatf("basic[%0d].strb", r), 64'(period_strb), 64'(tbl[r].strb));
            check($sformatf("basic[%0d].trig", r), 64'(trig_out), 64'(tbl[r].trig));
            check($sformatf("basic[%0d].rx", r), 64'(rx_start), 64'(tbl[r].rx));
            check($sformatf("basic[%0d].done", r), 64'(done), 64'd0);
            check($sformatf("basic[%0d].gpio", r), 64'(gpio_out), 64'hA5);
        end
        seq_start = 1'b0;

        // Drain from pcnt=3: six more cycles, new gpio_w ignored, seq_en re-raise ignored
        seq_en = 1'b0;
        tick();
        check("drain.busy24", 64'(busy), 64'd1);
        check("drain.trig24", 64'(trig_out), 64'h9);
        check("drain.strb24", 64'(period_strb), 64'd0);
        gpio_w = 40'h3C;
        for (int k = 25; k <= 29; k++) begin
            if (k == 26) seq_en = 1'b1;
            tick();
            check($sformatf("drain[%0d].done", k), 64'(done), 64'd0);
            check($sformatf("drain[%0d].busy", k), 64'(busy), 64'd1);
        end
        tick();
        check("drain.done", 64'(done), 64'd1);
        check("drain.busy_end", 64'(busy), 64'd0);
        check("drain.trig_end", 64'(trig_out), 64'd0);
        check("drain.gpio_end", 64'(gpio_out), 64'hA5);
        check("drain.strb_end", 64'(period_strb), 64'd0);
        tick();
        check("drain.done_once", 64'(done), 64'd0);
        check("drain.busy_after", 64'(busy), 64'd0);
        check("drain.gpio_after", 64'(gpio_out), 64'hA5);

        // External trigger: ARM for 20 cycles, run starts the cycle after the edge
        gpio_w      = 40'h5A;
        ext_trig_en = 1'b1;
        start_run();
        check("arm.busy", 64'(busy), 64'd1);
        check("arm.strb", 64'(period_strb), 64'd0);
        check("arm.gpio_hold", 64'(gpio_out), 64'hA5);
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("arm[%0d].busy", c), 64'(busy), 64'd1);
            check($sformatf("arm[%0d].strb", c), 64'(period_strb), 64'd0);
        end
        ext_trig = 1'b1;
        tick();
        ext_trig = 1'b0;
        check("arm.run_strb", 64'(period_strb), 64'd1);
        check("arm.run_gpio", 64'(gpio_out), 64'h5A);
        check("arm.run_busy", 64'(busy), 64'd1);
        seq_en = 1'b0;
        tick();
        wait_done(15, "arm.run_done");
        check("arm.run_idle", 64'(busy), 64'd0);

        // ARM abort: seq_en drop wins over a simultaneous trigger edge, no done
        seq_en = 1'b1;
        start_run();
        check("abort.busy_arm", 64'(busy), 64'd1);
        tick();
        tick();
        seq_en   = 1'b0;
        ext_trig = 1'b1;
        tick();
        ext_trig = 1'b0;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.done", 64'(done), 64'd0);
        check("abort.strb", 64'(period_strb), 64'd0);
        tick();
        check("abort.done2", 64'(done), 64'd0);
        check("abort.busy2", 64'(busy), 64'd0);

        // period_len = 0: strobe stays high every cycle
        ext_trig_en     = 1'b0;
        seq_en          = 1'b1;
        gpio_change_cnt = 32'd0;
        gpio_w          = 40'h11;
        start_run();
        check("len0.strb0", 64'(period_strb), 64'd1);
        for (int c = 1; c <= 8; c++) begin
            tick();
            check($sformatf("len0[%0d].strb", c), 64'(period_strb), 64'd1);
            check($sformatf("len0[%0d].gpio", c), 64'(gpio_out), 64'h11);
        end
        seq_en = 1'b0;
        wait_done(4, "len0.done");
        check("len0.idle", 64'(busy), 64'd0);
        gpio_change_cnt = 32'd9;
        gpio_w          = 40'hA5;
        seq_en          = 1'b1;

        // rx_delay_cnt = 0: single pulse in second RUN cycle
        rx_delay_cnt = 4'd0;
        start_run();
        check("rx0[0]", 64'(rx_start), 64'd0);
        for (int k = 1; k <= 25; k++) begin
            tick();
            check($sformatf("rx0[%0d]", k), 64'(rx_start), 64'(k == 1));
        end
        seq_en = 1'b0;
        wait_done(15, "rx0.done");
        seq_en = 1'b1;

        // rx_delay_cnt = 15: counter reaches 15 in RUN cycle 15, pulse one cycle later
        rx_delay_cnt = 4'd15;
        start_run();
        check("rx15[0]", 64'(rx_start), 64'd0);
        for (int k = 1; k <= 30; k++) begin
            tick();
            check($sformatf("rx15[%0d]", k), 64'(rx_start), 64'(k == 16));
        end
        seq_en = 1'b0;
        wait_done(15, "rx15.done");
        seq_en       = 1'b1;
        rx_delay_cnt = 4'd3;

        // Async reset mid-RUN at a falling edge, seq_start held high across release
        start_run();
        repeat (5) tick();
        check("areset.pre_trig", 64'(trig_out), 64'h9);
        check("areset.pre_busy", 64'(busy), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("areset");
        seq_start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("norestart[%0d].busy", c), 64'(busy), 64'd0);
            check($sformatf("norestart[%0d].strb", c), 64'(period_strb), 64'd0);
        end
        seq_start = 1'b0;
        tick();
        start_run();
        check("restart.busy", 64'(busy), 64'd1);
        check("restart.strb", 64'(period_strb), 64'd1);
        check("restart.gpio", 64'(gpio_out), 64'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
